vid_timing_mon: RTL and testbench

VID_TIMING_MON -- requirements
Module: vid_timing_mon

---
 rtl/vid_timing_mon.sv | 222 ++++++++++++++++++++++
 tb/tb_vid_timing_mon.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_mon.sv
// rtl/vid_timing_mon.sv - video timing measurement with frame lock tracking and grey-ramp pixel checker
module vid_timing_mon #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    output logic [H_BITS-1:0] h_total,
    output logic [H_BITS-1:0] hs_width,
    output logic [H_BITS-1:0] hact_start,
    output logic [H_BITS-1:0] hact_width,
    output logic [V_BITS-1:0] v_total,
    output logic [V_BITS-1:0] vs_width,
    output logic [V_BITS-1:0] vact_lines,
    output logic              locked,
    output logic              lock_lost,
    output logic              pix_err,
    output logic [15:0]       err_cnt,
    output logic [15:0]       frame_cnt
);
    localparam int RW = 4*H_BITS + 3*V_BITS;
    localparam logic [H_BITS-1:0] H_MAX = '1;
    localparam logic [V_BITS-1:0] V_MAX = '1;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
    state_t state;

    // A sync that is already high when reset releases must be seen low before it may rise.
    logic hs_d, vs_d, hs_arm, vs_arm;
    logic hs_rise, vs_rise;
    assign hs_rise = hs & ~hs_d & hs_arm;
    assign vs_rise = vs & ~vs_d & vs_arm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_d   <= 1'b0;
            vs_d   <= 1'b0;
            hs_arm <= 1'b0;
            vs_arm <= 1'b0;
        end else begin
            hs_d <= hs;
            vs_d <= vs;
            if (!hs) hs_arm <= 1'b1;
            if (!vs) vs_arm <= 1'b1;
        end
    end

    logic [H_BITS-1:0] x, hs_acc, vld_acc, first_x;
    logic [H_BITS-1:0] x_inc, hs_inc, vld_inc;
    logic              line_vld;
    assign x_inc   = (x == H_MAX) ? x : x + 1'b1;
    assign hs_inc  = (hs_acc == H_MAX) ? hs_acc : hs_acc + 1'b1;
    assign vld_inc = (vld_acc == H_MAX) ? vld_acc : vld_acc + 1'b1;

    // The rise cycle itself opens the new line, so its hs/vld are counted there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x        <= '0;
            hs_acc   <= '0;
            vld_acc  <= '0;
            first_x  <= '0;
            line_vld <= 1'b0;
        end else if (hs_rise) begin
            x        <= '0;
            hs_acc   <= H_BITS'(1);
            vld_acc  <= H_BITS'(vld);
            first_x  <= '0;
            line_vld <= vld;
        end else begin
            x <= x_inc;
            if (hs) hs_acc <= hs_inc;
            if (vld) begin
                vld_acc  <= vld_inc;
                line_vld <= 1'b1;
                if (!line_vld) first_x <= x;
            end
        end
    end

    logic [V_BITS-1:0] y, vs_lines, act_lines;
    logic [V_BITS-1:0] y_n, vs_lines_n, act_lines_n;
    logic [H_BITS-1:0] c_tot, c_hsw, c_hst, c_hw;
    logic [H_BITS-1:0] c_tot_n, c_hsw_n, c_hst_n, c_hw_n;
    logic              fvld, fvld_n;

    // Line close is folded in before frame close so a coincident hs_rise lands in the ending frame.
    always_comb begin
        y_n         = y;
        vs_lines_n  = vs_lines;
        act_lines_n = act_lines;
        c_tot_n     = c_tot;
        c_hsw_n     = c_hsw;
        c_hst_n     = c_hst;
        c_hw_n      = c_hw;
        fvld_n      = fvld;
        if (hs_rise) begin
            y_n = (y == V_MAX) ? y : y + 1'b1;
            if (vs_d) vs_lines_n = (vs_lines == V_MAX) ? vs_lines : vs_lines + 1'b1;
            if (line_vld) act_lines_n = (act_lines == V_MAX) ? act_lines : act_lines + 1'b1;
            if (line_vld || !fvld) begin
                c_tot_n = x_inc;
                c_hsw_n = hs_acc;
                c_hst_n = first_x;
                c_hw_n  = vld_acc;
            end
            fvld_n = fvld | line_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= '0;
            vs_lines  <= '0;
            act_lines <= '0;
            c_tot     <= '0;
            c_hsw     <= '0;
            c_hst     <= '0;
            c_hw      <= '0;
            fvld      <= 1'b0;
        end else begin
            c_tot <= c_tot_n;
            c_hsw <= c_hsw_n;
            c_hst <= c_hst_n;
            c_hw  <= c_hw_n;
            if (vs_rise) begin
                y         <= '0;
                vs_lines  <= '0;
                act_lines <= '0;
                fvld      <= 1'b0;
            end else begin
                y         <= y_n;
                vs_lines  <= vs_lines_n;
                act_lines <= act_lines_n;
                fvld      <= fvld_n;
            end
        end
    end

    logic [RW-1:0] cur_rec, prev_rec;
    logic          prev_valid, rec_eq, lock_chg;
    assign cur_rec  = {c_tot_n, c_hsw_n, c_hst_n, c_hw_n, y_n, vs_lines_n, act_lines_n};
    assign rec_eq   = prev_valid && (cur_rec == prev_rec);
    assign lock_chg = vs_rise && (((state == ACQUIRE) && rec_eq) || ((state == LOCKED) && !rec_eq));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEARCH;
            prev_valid <= 1'b0;
            prev_rec   <= '0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            frame_cnt  <= '0;
            h_total    <= '0;
            hs_width   <= '0;
            hact_start <= '0;
            hact_width <= '0;
            v_total    <= '0;
            vs_width   <= '0;
            vact_lines <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (vs_rise) begin
                if (state != SEARCH) frame_cnt <= frame_cnt + 16'd1;
                case (state)
                    SEARCH: begin
                        state      <= ACQUIRE;
                        prev_valid <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (rec_eq) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            {h_total, hs_width, hact_start, hact_width,
                             v_total, vs_width, vact_lines} <= cur_rec;
                        end else begin
                            prev_rec   <= cur_rec;
                            prev_valid <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!rec_eq) begin
                            state     <= ACQUIRE;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            prev_rec  <= cur_rec;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    logic [PW-1:0] r, g, b, prev_r;
    logic          have_prev, seq_bad, pix_bad;
    assign r       = rgb[3*PW-1:2*PW];
    assign g       = rgb[2*PW-1:PW];
    assign b       = rgb[PW-1:0];
    assign seq_bad = have_prev && (r != PW'(prev_r + 1'b1));
    assign pix_bad = vld && ((r != g) || (g != b) || seq_bad);

    // Any lock change restarts the ramp so the next pixel is not held to the old sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_prev <= 1'b0;
            prev_r    <= '0;
            pix_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            pix_err <= pix_bad;
            if (pix_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
            if (vld) prev_r <= r;
            if (lock_chg) have_prev <= 1'b0;
            else if (vld) have_prev <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vid_timing_mon.sv
// tb/tb_vid_timing_mon.sv - randomized self-checking bench for vid_timing_mon
module tb_vid_timing_mon;
    localparam int PW = 8;
    localparam int HB = 12;
    localparam int VB = 12;

    logic            clk = 1'b0;
    logic            rst_n, hs, vs, vld;
    logic [3*PW-1:0] rgb;
    logic [HB-1:0]   h_total, hs_width, hact_start, hact_width;
    logic [VB-1:0]   v_total, vs_width, vact_lines;
    logic            locked, lock_lost, pix_err;
    logic [15:0]     err_cnt, frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vid_timing_mon #(.PW(PW), .H_BITS(HB), .V_BITS(VB)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .h_total(h_total), .hs_width(hs_width), .hact_start(hact_start), .hact_width(hact_width),
        .v_total(v_total), .vs_width(vs_width), .vact_lines(vact_lines),
        .locked(locked), .lock_lost(lock_lost), .pix_err(pix_err),
        .err_cnt(err_cnt), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Frame timing described by line/pixel positions; vs rises at row 0, pixel 0.
    typedef struct {
        int hend, hs_s, hs_e, ha_s, ha_e;
        int vend, vs_e, va_s, va_e;
        bit act;
    } cfg_t;

    typedef struct packed {
        logic [31:0] ht, hsw, hst, hw, vt, vsw, va;
    } rec_t;

    function automatic rec_t expect_rec(input cfg_t c);
        rec_t e;
        e.ht  = c.hend + 1;
        e.hsw = c.hs_e - c.hs_s;
        e.hst = c.act ? c.ha_s - c.hs_s - 1 : 0;
        e.hw  = c.act ? c.ha_e - c.ha_s : 0;
        e.vt  = c.vend + 1;
        e.vsw = c.vs_e;
        e.va  = c.act ? c.va_e - c.va_s : 0;
        return e;
    endfunction

    int          m_state;
    bit          m_prev_ok, m_have, m_ll, exp_perr;
    rec_t        m_prev, m_out, m_cur;
    int          m_fcnt, m_err, m_err_total, m_ll_total;
    logic [7:0]  m_prev_r, pr;
    int          ll_seen = 0, pe_seen = 0, lit_mode = 0;

    always @(negedge clk) begin
        if (lock_lost === 1'b1) ll_seen++;
        if (pix_err === 1'b1) pe_seen++;
    end

    task automatic model_reset();
        m_state = 0; m_prev_ok = 0; m_have = 0; m_ll = 0;
        m_prev = '0; m_out = '0; m_fcnt = 0; m_err = 0; exp_perr = 0;
    endtask

    task automatic model_vs_rise();
        m_ll = 0;
        if (m_state == 0) begin
            m_state = 1;
            m_prev_ok = 0;
        end else begin
            m_fcnt = (m_fcnt + 1) % 65536;
            if (m_state == 1) begin
                if (m_prev_ok && m_cur == m_prev) begin
                    m_state = 2; m_out = m_cur; m_have = 0;
                end else begin
                    m_prev = m_cur; m_prev_ok = 1;
                end
            end else if (m_cur != m_prev) begin
                m_state = 1; m_prev = m_cur; m_ll = 1; m_have = 0; m_ll_total++;
            end
        end
    endtask

    task automatic check_outs(input string t);
        chk({t, "_locked"}, locked, m_state == 2);
        chk({t, "_lock_lost"}, lock_lost, m_ll);
        chk({t, "_h_total"}, h_total, m_out.ht);
        chk({t, "_hs_width"}, hs_width, m_out.hsw);
        chk({t, "_hact_start"}, hact_start, m_out.hst);
        chk({t, "_hact_width"}, hact_width, m_out.hw);
        chk({t, "_v_total"}, v_total, m_out.vt);
        chk({t, "_vs_width"}, vs_width, m_out.vsw);
        chk({t, "_vact_lines"}, vact_lines, m_out.va);
        chk({t, "_frame_cnt"}, frame_cnt, m_fcnt);
        chk({t, "_err_cnt"}, err_cnt, m_err);
        chk({t, "_pix_err"}, pix_err, exp_perr);
    endtask

    task automatic lit_checks();
        case (lit_mode)
            1: begin
                chk("lit_locked", locked, 1); chk("lit_h_total", h_total, 101);
                chk("lit_hs_width", hs_width, 10); chk("lit_hact_width", hact_width, 64);
                chk("lit_v_total", v_total, 61); chk("lit_vs_width", vs_width, 2);
                chk("lit_vact_lines", vact_lines, 45); chk("lit_err_cnt0", err_cnt, 0);
                chk("lit_frame_cnt5", frame_cnt, 5);
            end
            2: begin chk("lit_err_cnt1", err_cnt, 1); chk("lit_pix_err_once", pe_seen, 1); end
            3: begin chk("lit_relock", locked, 1); chk("lit_h_total121", h_total, 121); end
            4: begin
                chk("lit_novld_locked", locked, 1); chk("lit_novld_hact_start", hact_start, 0);
                chk("lit_novld_hact_width", hact_width, 0); chk("lit_novld_vact", vact_lines, 0);
            end
            default: ;
        endcase
        lit_mode = 0;
    endtask

    task automatic drive_frame(input cfg_t c, input int rows, input int inj_row, input int inj_h,
                               input int rst_row, input int rst_h, input int rate);
        logic [7:0] r, g, bb;
        bit act, bad, rst_pend;
        rst_pend = 0;
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h <= c.hend; h++) begin
                @(negedge clk);
                if (rst_pend) begin
                    check_outs("midreset");
                    rst_n = 1'b1;
                    rst_pend = 0;
                end else begin
                    chk("pix_err", pix_err, exp_perr);
                    if (v == 0 && h == 1) begin
                        check_outs("frame");
                        lit_checks();
                    end
                end
                if (v == 0 && h == 0) begin
                    model_vs_rise();
                    m_cur = expect_rec(c);
                end
                hs = (h >= c.hs_s) && (h < c.hs_e);
                vs = (v < c.vs_e);
                act = c.act && (v >= c.va_s) && (v < c.va_e) && (h >= c.ha_s) && (h < c.ha_e);
                vld = act;
                exp_perr = 0;
                if (act) begin
                    r = pr; g = pr; bb = pr;
                    if (v == inj_row && h == inj_h) g = r ^ 8'd1;
                    else if (rate > 0 && $urandom_range(rate - 1) == 0) begin
                        if ($urandom_range(1) == 0) g = r ^ 8'd1;
                        else begin r = r + 8'd2; g = r; bb = r; end
                    end
                    bad = (r != g) || (g != bb) || (m_have && (r != 8'(m_prev_r + 8'd1)));
                    m_have = 1; m_prev_r = r; pr = r + 8'd1;
                    if (bad) begin
                        m_err_total++;
                        if (m_err < 65535) m_err++;
                    end
                    exp_perr = bad;
                    rgb = {r, g, bb};
                end else begin
                    rgb = 24'($urandom);
                end
                if (v == rst_row && h == rst_h) begin
                    rst_n = 1'b0;
                    model_reset();
                    rst_pend = 1;
                end
            end
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.hend = $urandom_range(60, 30);
        c.hs_s = $urandom_range(4, 1);
        c.hs_e = c.hs_s + $urandom_range(6, 1);
        c.ha_s = c.hs_s + $urandom_range(8, 2);
        c.ha_e = c.ha_s + $urandom_range(c.hend + 1 - c.ha_s, 1);
        c.vend = $urandom_range(14, 8);
        c.vs_e = $urandom_range(3, 1);
        c.va_s = $urandom_range(3, 1);
        c.va_e = $urandom_range(c.vend, c.va_s + 1);
        c.act  = ($urandom_range(3) != 0);
        return c;
    endfunction

    cfg_t ca, cc, cd, ce, cr;

    initial begin
        m_err_total = 0; m_ll_total = 0; pr = 8'd0; m_prev_r = 8'd0; m_cur = '0;
        model_reset();
        rst_n = 1'b0; hs = 0; vs = 0; vld = 0; rgb = '0;
        repeat (3) @(negedge clk);
        check_outs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        ca = '{hend: 100, hs_s: 10, hs_e: 20, ha_s: 30, ha_e: 94,
               vend: 60, vs_e: 2, va_s: 5, va_e: 50, act: 1'b1};
        for (int f = 0; f < 5; f++) drive_frame(ca, ca.vend + 1, -1, -1, -1, -1, 0);
        lit_mode = 1;
        drive_frame(ca, ca.vend + 1, 20, 40, -1, -1, 0);

        cc = ca; cc.hend = 120;
        lit_mode = 2;
        for (int f = 0; f < 2; f++) drive_frame(cc, cc.vend + 1, -1, -1, -1, -1, 0);

        cd = '{hend: 47, hs_s: 3, hs_e: 9, ha_s: 12, ha_e: 40,
               vend: 11, vs_e: 2, va_s: 2, va_e: 9, act: 1'b1};
        lit_mode = 3;
        drive_frame(cd, cd.vend + 1, -1, -1, 1, 5, 0);
        for (int f = 0; f < 3; f++) drive_frame(cd, cd.vend + 1, -1, -1, -1, -1, 0);

        ce = cd; ce.act = 1'b0;
        for (int f = 0; f < 3; f++) drive_frame(ce, ce.vend + 1, -1, -1, -1, -1, 0);
        lit_mode = 4;

        for (int k = 0; k < 3; k++) begin
            cr = rand_cfg();
            for (int f = 0, n = $urandom_range(3, 2); f < n; f++)
                drive_frame(cr, cr.vend + 1, -1, -1, -1, -1, 40);
        end
        drive_frame(cd, 1, -1, -1, -1, -1, 0);

        chk("lock_lost_pulses", ll_seen, m_ll_total);
        chk("pix_err_pulses", pe_seen, m_err_total);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
